// File: rtl/seq_multiplier_if.sv
// Host-side handshake and operand/result bundle for seq_multiplier.
// The host drives it through the master modport and the multiplier through the slave modport.
interface seq_multiplier_if #(
    parameter int N = 8
);
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic [2*N-1:0] product;
    logic           busy;
    logic           ready;
    logic           done;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  product, busy, ready, done
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output product, busy, ready, done
    );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier for unsigned or radix-2 Booth signed operands.
// SKIP_NOP=1 bypasses the ADD phase for bits that need no add/subtract.
module seq_multiplier #(
    parameter int N        = 8,
    parameter bit SKIP_NOP = 1'b0
) (
    input  logic           clock,
    input  logic           reset,
    seq_multiplier_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [N:0]     a_q, a_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   m_q, m_d;
    logic           qm1_q, qm1_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           mode_q, mode_d;
    logic           dec_q, dec_d;
    logic [2*N-1:0] product_q, product_d;
    logic           busy_q, busy_d;
    logic           ready_q, ready_d;
    logic           done_q, done_d;

    logic [N:0]     m_ext_s;
    logic [N:0]     a_sh_s;
    logic [N-1:0]   q_sh_s;
    logic           qm1_sh_s;
    logic           next_op_s;
    logic           skip0_s;
    logic [CW-1:0]  cnt_sh_s;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        dec_d     = dec_q;
        product_d = product_q;

        m_ext_s   = mode_q ? {m_q[N-1], m_q} : {1'b0, m_q};
        a_sh_s    = {(mode_q ? a_q[N] : 1'b0), a_q[N:1]};
        q_sh_s    = {a_q[0], q_q[N-1:1]};
        qm1_sh_s  = q_q[0];
        next_op_s = mode_q ? (q_sh_s[0] ^ qm1_sh_s) : q_sh_s[0];
        skip0_s   = (SKIP_NOP == 1'b1) && !bus.multiplier[0];
        // a skipped ADD leaves its count decrement to the following SHIFT
        cnt_sh_s  = dec_q ? (cnt_q - CW'(1)) : cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d     = '0;
                    q_d     = bus.multiplier;
                    m_d     = bus.multiplicand;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(N);
                    mode_d  = bus.signed_mode;
                    dec_d   = skip0_s;
                    state_d = skip0_s ? S_SHIFT : S_ADD;
                end else begin
                    state_d = state_q;
                end
            end
            S_ADD: begin
                if (mode_q) begin
                    case ({q_q[0], qm1_q})
                        2'b10:   a_d = a_q - m_ext_s;
                        2'b01:   a_d = a_q + m_ext_s;
                        default: a_d = a_q;
                    endcase
                end else if (q_q[0]) begin
                    a_d = a_q + m_ext_s;
                end else begin
                    a_d = a_q;
                end
                cnt_d   = cnt_q - CW'(1);
                dec_d   = 1'b0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                a_d   = a_sh_s;
                q_d   = q_sh_s;
                qm1_d = qm1_sh_s;
                cnt_d = cnt_sh_s;
                if (cnt_sh_s == CW'(0)) begin
                    product_d = {a_sh_s[N-1:0], q_sh_s};
                    dec_d     = 1'b0;
                    state_d   = S_DONE;
                end else if ((SKIP_NOP == 1'b1) && !next_op_s) begin
                    dec_d     = 1'b1;
                    state_d   = S_SHIFT;
                end else begin
                    dec_d     = 1'b0;
                    state_d   = S_ADD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d == S_ADD) || (state_d == S_SHIFT);
        ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
        done_d  = (state_d == S_DONE) && (state_q != S_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            dec_q     <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            dec_q     <= dec_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed scoreboard bench: three multiplier instances (N=4 fixed/skip, N=8 skip),
// expected product/latency queued at issue and checked by a forked monitor on done.
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_multiplier_if #(.N(4)) b0 ();
    seq_multiplier_if #(.N(4)) b1 ();
    seq_multiplier_if #(.N(8)) b2 ();

    seq_multiplier #(.N(4), .SKIP_NOP(1'b0)) u0 (.clock(clk), .reset(rst), .bus(b0));
    seq_multiplier #(.N(4), .SKIP_NOP(1'b1)) u1 (.clock(clk), .reset(rst), .bus(b1));
    seq_multiplier #(.N(8), .SKIP_NOP(1'b1)) u2 (.clock(clk), .reset(rst), .bus(b2));

    typedef struct {
        logic [15:0] p;
        int          lat;
        int          c0;
    } exp_t;

    exp_t sb[3][$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   bc[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic mon_one(input int k, input logic done, input logic busy, input logic [15:0] prod);
        exp_t e;
        if (done) begin
            if (sb[k].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut%0d_done: got unexpected done (product %h), required none", k, prod);
            end else begin
                e = sb[k].pop_front();
                chk($sformatf("dut%0d_product", k), prod, e.p);
                chk($sformatf("dut%0d_latency", k), 16'(cyc - e.c0), 16'(e.lat));
                chk($sformatf("dut%0d_busy_cycles", k), 16'(bc[k]), 16'(e.lat - 1));
            end
            bc[k] = 0;
        end else if (busy) begin
            bc[k]++;
        end else begin
            bc[k] = 0;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            mon_one(0, b0.done, b0.busy, {8'h00, b0.product});
            mon_one(1, b1.done, b1.busy, {8'h00, b1.product});
            mon_one(2, b2.done, b2.busy, b2.product);
        end
    endtask

    task automatic wait_ready0();
        int i = 0;
        while (!b0.ready && i < 64) begin
            @(negedge clk);
            i++;
        end
        chk("dut0_ready_wait", {15'd0, b0.ready}, 16'd1);
    endtask

    task automatic go4(input int k, input bit sm, input logic [3:0] m, input logic [3:0] q,
                       input logic [15:0] p, input int lat);
        exp_t e;
        int   i = 0;
        while (!(k == 0 ? b0.ready : b1.ready) && i < 64) begin
            @(negedge clk);
            i++;
        end
        chk($sformatf("dut%0d_ready_wait", k), {15'd0, (k == 0 ? b0.ready : b1.ready)}, 16'd1);
        if (k == 0) begin
            b0.signed_mode = sm; b0.multiplicand = m; b0.multiplier = q; b0.start = 1'b1;
        end else begin
            b1.signed_mode = sm; b1.multiplicand = m; b1.multiplier = q; b1.start = 1'b1;
        end
        e = '{p, lat, cyc};
        sb[k].push_back(e);
        @(negedge clk);
        if (k == 0) b0.start = 1'b0;
        else        b1.start = 1'b0;
    endtask

    task automatic go8(input bit sm, input logic [7:0] m, input logic [7:0] q,
                       input logic [15:0] p, input int lat);
        exp_t e;
        int   i = 0;
        while (!b2.ready && i < 64) begin
            @(negedge clk);
            i++;
        end
        chk("dut2_ready_wait", {15'd0, b2.ready}, 16'd1);
        b2.signed_mode = sm; b2.multiplicand = m; b2.multiplier = q; b2.start = 1'b1;
        e = '{p, lat, cyc};
        sb[2].push_back(e);
        @(negedge clk);
        b2.start = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   i;
        bc[0] = 0; bc[1] = 0; bc[2] = 0;
        b0.start = 1'b0; b0.signed_mode = 1'b0; b0.multiplicand = 4'h0; b0.multiplier = 4'h0;
        b1.start = 1'b0; b1.signed_mode = 1'b0; b1.multiplicand = 4'h0; b1.multiplier = 4'h0;
        b2.start = 1'b0; b2.signed_mode = 1'b0; b2.multiplicand = 8'h00; b2.multiplier = 8'h00;

        repeat (2) @(negedge clk);
        chk("reset_product", {8'h00, b0.product}, 16'h0000);
        chk("reset_ready",   {15'd0, b0.ready}, 16'd1);
        chk("reset_busy",    {15'd0, b0.busy},  16'd0);
        chk("reset_done",    {15'd0, b0.done},  16'd0);
        rst = 1'b0;
        fork
            monitor();
        join_none
        @(negedge clk);

        // fixed latency, N=4
        go4(0, 1'b0, 4'hF, 4'hF, 16'h00E1, 9);
        go4(0, 1'b1, 4'h8, 4'h8, 16'h0040, 9);
        go4(0, 1'b1, 4'hD, 4'h5, 16'h00F1, 9);
        go4(0, 1'b1, 4'h7, 4'hF, 16'h00F9, 9);
        go4(0, 1'b0, 4'h9, 4'hF, 16'h0087, 9);
        go4(0, 1'b0, 4'h0, 4'h0, 16'h0000, 9);

        // start while busy with different operands is ignored
        go4(0, 1'b0, 4'h5, 4'h3, 16'h000F, 9);
        @(negedge clk);
        b0.multiplicand = 4'hF; b0.multiplier = 4'hF; b0.signed_mode = 1'b1; b0.start = 1'b1;
        repeat (2) @(negedge clk);
        b0.start = 1'b0;

        // back-to-back: start held through DONE
        wait_ready0();
        b0.signed_mode = 1'b0; b0.multiplicand = 4'h2; b0.multiplier = 4'h3; b0.start = 1'b1;
        e = '{16'h0006, 9, cyc};
        sb[0].push_back(e);
        @(negedge clk);
        b0.multiplicand = 4'h4; b0.multiplier = 4'h5;
        i = 0;
        while (!b0.done && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("dut0_b2b_done_wait", {15'd0, b0.done}, 16'd1);
        e = '{16'h0014, 9, cyc};
        sb[0].push_back(e);
        @(negedge clk);
        b0.start = 1'b0;

        // asynchronous reset while in SHIFT
        wait_ready0();
        b0.signed_mode = 1'b0; b0.multiplicand = 4'hF; b0.multiplier = 4'hF; b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_product", {8'h00, b0.product}, 16'h0000);
        chk("midreset_ready",   {15'd0, b0.ready}, 16'd1);
        chk("midreset_busy",    {15'd0, b0.busy},  16'd0);
        chk("midreset_done",    {15'd0, b0.done},  16'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        go4(0, 1'b0, 4'h5, 4'h3, 16'h000F, 9);

        // add-skip, N=4
        go4(1, 1'b0, 4'h9, 4'h0, 16'h0000, 5);
        go4(1, 1'b0, 4'h9, 4'hF, 16'h0087, 9);
        go4(1, 1'b1, 4'hD, 4'h5, 16'h00F1, 9);
        go4(1, 1'b1, 4'h7, 4'hF, 16'h00F9, 6);
        go4(1, 1'b1, 4'h8, 4'h8, 16'h0040, 6);
        go4(1, 1'b0, 4'h3, 4'h6, 16'h0012, 7);

        // add-skip, N=8
        go8(1'b1, 8'h80, 8'h80, 16'h4000, 10);
        go8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 17);
        go8(1'b1, 8'hFF, 8'hFF, 16'h0001, 10);
        go8(1'b1, 8'h64, 8'hFD, 16'hFED4, 12);
        go8(1'b0, 8'hC8, 8'h03, 16'h0258, 11);

        i = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("scoreboard_drained", 16'(sb[0].size() + sb[1].size() + sb[2].size()), 16'd0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
